bram_load_ctrl: RTL

- Run-time loader/sequencer for the MicroBlaze LMB instruction BRAM. The BRAM is built from NUM_MEM striped devices; each device holds a WIDTH-bit slice of every 32-bit word at a common word address.
- Accepts a program image as a stream of 32-bit words, writes it into all device slices, then reads the image back and verifies it against a 32-bit modular checksum.
- Holds the CPU in reset until a load verifies. Replaces elaboration-time INIT_XX preloading when the image changes without re-synthesis.

---
 rtl/bram_load_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bram_load_ctrl.sv
// Run-time program loader for a striped LMB instruction BRAM: streams an image
// into every device slice, reads it back, verifies a 32-bit modular checksum and
// releases the CPU reset only after a verified load.
module bram_load_ctrl #(
  parameter  int unsigned MEM_SIZE = 64,
  parameter  int unsigned NUM_MEM  = 16,
  localparam int unsigned DEPTH    = MEM_SIZE * 256,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bram_en,
  output logic [NUM_MEM-1:0] bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_VERIFY, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      n_q, n_d;
  logic [CW-1:0]      acount_q, acount_d;
  logic [CW-1:0]      vcnt_q, vcnt_d;
  logic [31:0]        sum_w_q, sum_w_d;
  logic [31:0]        sum_r_q, sum_r_d;
  logic               s_ready_q, s_ready_d;
  logic               bram_en_q, bram_en_d;
  logic [NUM_MEM-1:0] bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
  logic [31:0]        bram_wdata_q, bram_wdata_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    acount_d     = acount_q;
    vcnt_d       = vcnt_q;
    sum_w_d      = sum_w_q;
    sum_r_d      = sum_r_q;
    s_ready_d    = 1'b0;
    bram_en_d    = 1'b0;
    bram_we_d    = '0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_code_d  = 2'd0;
          cpu_rst_n_d = 1'b0;
          n_d         = word_count;
          acount_d    = '0;
          vcnt_d      = '0;
          sum_w_d     = '0;
          sum_r_d     = '0;
          if (word_count > CW'(DEPTH)) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = 2'd1;
          end else if (word_count == '0) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            state_d   = S_LOAD;
            s_ready_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (s_valid && s_ready_q) begin
          bram_en_d    = 1'b1;
          bram_we_d    = '1;
          bram_addr_d  = ADDR_W'(acount_q);
          bram_wdata_d = s_data;
          acount_d     = acount_q + CW'(1);
          sum_w_d      = sum_w_q + s_data;
        end
        s_ready_d = (acount_d < n_q);
        // Last write is on the port this cycle; start readback with address 0.
        if (acount_q == n_q) begin
          state_d     = S_VERIFY;
          vcnt_d      = '0;
          bram_en_d   = 1'b1;
          bram_addr_d = '0;
        end
      end

      S_VERIFY: begin
        if (vcnt_q != '0) begin
          sum_r_d = sum_r_q + bram_rdata;
        end
        if ((vcnt_q + CW'(1)) < n_q) begin
          bram_en_d   = 1'b1;
          bram_addr_d = ADDR_W'(vcnt_q + CW'(1));
        end
        vcnt_d = vcnt_q + CW'(1);
        if (vcnt_q == n_q) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (sum_r_q == sum_w_q) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          cpu_rst_n_d = 1'b1;
        end else begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = 2'd2;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_CHECK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      acount_q     <= '0;
      vcnt_q       <= '0;
      sum_w_q      <= '0;
      sum_r_q      <= '0;
      s_ready_q    <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      acount_q     <= acount_d;
      vcnt_q       <= vcnt_d;
      sum_w_q      <= sum_w_d;
      sum_r_q      <= sum_r_d;
      s_ready_q    <= s_ready_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign bram_en    = bram_en_q;
  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;

endmodule
